// File: rtl/viterbi_frame_ctrl_if.sv
// Handshake and datapath bundle between the Viterbi frame sequencer, its
// symbol source, the external ACS unit and the decoded-bit sink.
interface viterbi_frame_ctrl_if;
  logic       start;
  logic       busy;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       acs_init;
  logic       acs_go;
  logic [1:0] acs_sym;
  logic       acs_done;
  logic [3:0] acs_dec;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       frame_done;
  logic       err;

  // Environment side: symbol source, ACS unit and bit sink.
  modport master (
    output start, sym_in, sym_valid, acs_done, acs_dec, bit_ready,
    input  busy, sym_ready, acs_init, acs_go, acs_sym, bit_out, bit_valid,
           frame_done, err
  );

  // Sequencer side.
  modport slave (
    input  start, sym_in, sym_valid, acs_done, acs_dec, bit_ready,
    output busy, sym_ready, acs_init, acs_go, acs_sym, bit_out, bit_valid,
           frame_done, err
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a 4-state K=3 rate-1/2 Viterbi decoder. Feeds one
// terminated frame of symbol pairs through an external ACS unit, keeps the
// per-step decision vectors, traces back from state 00 and streams the info
// bits out in order. Trellis state is {newest bit, previous bit}, so the
// predecessor of state s is {s[0], dec[s]}.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN   = 5,
  parameter int ACS_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  viterbi_frame_ctrl_if.slave  bus
);
  localparam int N  = FRAME_LEN + 2;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(ACS_TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [CW-1:0] INFO_N    = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_INFO = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_ACS_WAIT, S_TB, S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] tb_idx_q, tb_idx_d;
  logic [CW-1:0] out_idx_q, out_idx_d;
  logic [1:0]    tb_st_q, tb_st_d;
  logic [1:0]    acs_sym_q, acs_sym_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic busy_q, busy_d;
  logic sym_ready_q, sym_ready_d;
  logic acs_init_q, acs_init_d;
  logic acs_go_q, acs_go_d;
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic frame_done_q, frame_done_d;
  logic err_q, err_d;

  logic [3:0] surv [N];
  logic       obuf [FRAME_LEN];
  logic       surv_we;
  logic       obuf_we;
  logic       tb_dec;

  // Next-state and next-output decode; outputs follow the state being entered.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    tb_idx_d     = tb_idx_q;
    out_idx_d    = out_idx_q;
    tb_st_d      = tb_st_q;
    acs_sym_d    = acs_sym_q;
    tmo_d        = tmo_q;
    acs_go_d     = 1'b0;
    err_d        = 1'b0;
    frame_done_d = 1'b0;
    surv_we      = 1'b0;
    obuf_we      = 1'b0;
    tb_dec       = surv[tb_idx_q][tb_st_q];

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          step_d  = '0;
        end
      end
      S_INIT: begin
        step_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (bus.sym_valid && sym_ready_q) begin
          acs_sym_d = bus.sym_in;
          tmo_d     = '0;
          acs_go_d  = 1'b1;
          state_d   = S_ACS_WAIT;
        end
      end
      S_ACS_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // The go cycle itself can never carry a valid done; a real done
        // beats a simultaneous timeout expiry.
        if (!acs_go_q && bus.acs_done) begin
          surv_we = 1'b1;
          if (step_q == LAST_STEP) begin
            tb_idx_d = LAST_STEP;
            tb_st_d  = 2'b00;
            state_d  = S_TB;
          end else begin
            step_d  = step_q + CW'(1);
            state_d = S_LOAD;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_TB: begin
        obuf_we = (tb_idx_q < INFO_N);
        tb_st_d = {tb_st_q[0], tb_dec};
        if (tb_idx_q == '0) begin
          out_idx_d = '0;
          state_d   = S_OUT;
        end else begin
          tb_idx_d = tb_idx_q - CW'(1);
        end
      end
      S_OUT: begin
        if (bit_valid_q && bus.bit_ready) begin
          if (out_idx_q == LAST_INFO) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            out_idx_d = out_idx_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    sym_ready_d = (state_d == S_LOAD);
    acs_init_d  = (state_d == S_INIT);
    bit_valid_d = (state_d == S_OUT);
    bit_out_d   = 1'b0;
    if (state_d == S_OUT) begin
      // obuf[0] is written on the last traceback cycle, so forward it.
      bit_out_d = (state_q == S_TB) ? tb_st_q[1] : obuf[out_idx_d];
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      tb_idx_q     <= '0;
      out_idx_q    <= '0;
      tb_st_q      <= 2'b00;
      acs_sym_q    <= 2'b00;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      sym_ready_q  <= 1'b0;
      acs_init_q   <= 1'b0;
      acs_go_q     <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      tb_idx_q     <= tb_idx_d;
      out_idx_q    <= out_idx_d;
      tb_st_q      <= tb_st_d;
      acs_sym_q    <= acs_sym_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      sym_ready_q  <= sym_ready_d;
      acs_init_q   <= acs_init_d;
      acs_go_q     <= acs_go_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Survivor and output buffers hold data only and are never cleared.
  always_ff @(posedge clk) begin
    if (surv_we) surv[step_q] <= bus.acs_dec;
    if (obuf_we) obuf[tb_idx_q] <= tb_st_q[1];
  end

  assign bus.busy       = busy_q;
  assign bus.sym_ready  = sym_ready_q;
  assign bus.acs_init   = acs_init_q;
  assign bus.acs_go     = acs_go_q;
  assign bus.acs_sym    = acs_sym_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;
endmodule
